tmds_deserializer: RTL and testbench
====================================

// Module: tmds_deserializer
//
// PURPOSE
//   Serial-to-parallel converter for the HDMI/TMDS receive path; the counterpart of the transmit-side serializers.
//   - Samples one bit per clk.
//   - Assembles SIZE-bit words, LSB first, matching the serializer shift order.
//   - Emits each word with a one-cycle valid strobe.
//   - Word boundary is moved by a bitslip request, or by the optional automatic aligner.
//
// PARAMETERS
//   SIZE          10    word width in bits (one TMDS symbol)
//   ALIGN_WINDOW  1024  words per alignment attempt (TMDS_ALIGN_EN only)
//   LOCK_COUNT    8     consecutive control tokens needed to declare lock (TMDS_ALIGN_EN only)
//
// PORTS
//   clk      in   1     bit clock; all logic on posedge
//   rst_n    in   1     synchronous, active-low reset
//   s_in     in   1     serial data, first received bit = word bit 0
//   bitslip  in   1     level-sampled; each high cycle slips boundary one bit later
//   p_out    out  SIZE  last completed word
//   p_valid  out  1     one-cycle strobe: p_out updated this cycle
//   locked   out  1     aligner lock status (0 when TMDS_ALIGN_EN undefined)
//
// BEHAVIOUR
//   Reset: rst_n sampled low at a posedge clears all state.
//     - sr, bit counter cnt, p_out, p_valid, locked, window/lock counters -> 0.
//     - Reset wins over every other input, including mid-word; the partial word is discarded.
//   Shift: every cycle sr <= {s_in, sr[SIZE-1:1]}.
//   Counter: cnt runs 0..SIZE-1 and wraps to 0; it holds its value (no increment) in any cycle where slip=1.
//     - slip = bitslip OR internal aligner slip.
//   Word completion: in a cycle with cnt==SIZE-1 and slip==0:
//     - p_out <= {s_in, sr[SIZE-1:1]}; p_valid <= 1.
//     - Otherwise p_valid <= 0; p_out holds.
//   Latency: word's last bit sampled at edge k -> p_out/p_valid valid after edge k.
//     - With no slips, the first word after reset release completes on the 10th sampled bit (SIZE=10); thereafter one strobe every SIZE cycles.
//   Slip at cnt==SIZE-1: completion deferred one cycle; the word then contains the next bit at its MSB.
//   bitslip held N cycles: N-bit slip; no p_valid while held.
//   Continuous operation: no flow control, no backpressure; the consumer must accept every strobe.
//
// CONFIGURATION
//   TMDS_ALIGN_EN defined:
//     - Automatic word alignment on TMDS control tokens 10'h354, 10'h0AB, 10'h154, 10'h2AB.
//     - On each completed word:
//       - Token match: run counter +1 (saturating). Non-token: run counter -> 0.
//       - Window counter +1.
//     - Lock: run counter reaches LOCK_COUNT -> locked <= 1.
//     - Once locked, locked stays 1 and no internal slips occur until reset or an external bitslip pulse (which clears locked and both counters).
//     - Window expiry: window counter reaches ALIGN_WINDOW while unlocked:
//       - One-cycle internal slip on the cycle after the ALIGN_WINDOW-th word.
//       - Window and run counters -> 0.
//     - Counter widths: $clog2(ALIGN_WINDOW+1) and $clog2(LOCK_COUNT+1).
//   TMDS_ALIGN_EN undefined:
//     - No aligner logic; locked tied 0; ALIGN_WINDOW/LOCK_COUNT unused.
//     - Alignment is solely via the bitslip port.
//
// TESTING (SIZE=10)
//   1. Reset release, send 10'h354 LSB first -> p_valid high exactly after 10th bit, p_out=10'h354, p_valid low next cycle.
//   2. Stream 10'h354,10'h0AB,10'h2AB back-to-back -> three strobes spaced 10 cycles, values in order.
//   3. Stream 10'h001 repeated; one-cycle bitslip mid-word -> all subsequent words = 10'h200, one strobe gap of 11 cycles.
//   4. rst_n low for 1 cycle at cnt=5 -> p_out=0, p_valid=0; next strobe exactly 10 bits after release.
//   5. bitslip held 3 cycles spanning cnt==9 -> no strobe during hold; boundary shifted by 3 bits.
//   6. (TMDS_ALIGN_EN, ALIGN_WINDOW=16, LOCK_COUNT=8) stream 10'h354 at 3-bit phase offset -> locked=1 within 2000 cycles, then every p_out=10'h354; without macro locked stays 0.

Source files
------------

// File: rtl/tmds_deserializer_if.sv
// Bus bundle for tmds_deserializer: serial input, bitslip request and the
// parallel word output with its strobe and aligner lock status.
interface tmds_deserializer_if #(
  parameter int unsigned SIZE = 10
);

  logic            s_in;
  logic            bitslip;
  logic [SIZE-1:0] p_out;
  logic            p_valid;
  logic            locked;

  // Source of serial data / consumer of parallel words
  modport master (
    output s_in,
    output bitslip,
    input  p_out,
    input  p_valid,
    input  locked
  );

  // The deserializer itself
  modport slave (
    input  s_in,
    input  bitslip,
    output p_out,
    output p_valid,
    output locked
  );

endinterface

// File: rtl/tmds_deserializer.sv
// TMDS receive-path deserializer: one bit per clk, SIZE-bit words assembled
// LSB first, one-cycle p_valid strobe per word. The word boundary moves one
// bit later for every cycle that bitslip (or the internal aligner) is high.
// Optional feature macro: TMDS_ALIGN_EN enables the automatic control-token
// aligner; without it locked is tied low.
module tmds_deserializer #(
  parameter int unsigned SIZE         = 10,
  parameter int unsigned ALIGN_WINDOW = 1024,
  parameter int unsigned LOCK_COUNT   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  tmds_deserializer_if.slave  bus
);

  localparam int unsigned     CNT_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

  // Reject parameter sets the datapath cannot represent
  if (SIZE < 2 || ALIGN_WINDOW < 1 || LOCK_COUNT < 1) begin : g_bad_param
    $error("tmds_deserializer: illegal parameter set");
  end

  // Only the upper SIZE-1 bits of the shift register are ever read, so bit 0
  // is not stored; the incoming bit completes the word directly.
  logic [SIZE-2:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic [SIZE-1:0]  p_out_q;
  logic             p_valid_q;

  logic             slip_c;
  logic             word_done_c;
  logic [SIZE-1:0]  word_c;

  assign word_c      = {bus.s_in, sr};
  assign word_done_c = (cnt == CNT_LAST) && !slip_c;

  // Shift register, bit counter (frozen while slipping) and word output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr        <= '0;
      cnt       <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
    end else begin
      sr        <= word_c[SIZE-1:1];
      p_valid_q <= 1'b0;
      if (!slip_c) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end
      if (word_done_c) begin
        p_out_q   <= word_c;
        p_valid_q <= 1'b1;
      end
    end
  end

  assign bus.p_out   = p_out_q;
  assign bus.p_valid = p_valid_q;

`ifdef TMDS_ALIGN_EN
  localparam int unsigned      WIN_W   = $clog2(ALIGN_WINDOW + 1);
  localparam int unsigned      RUN_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [WIN_W-1:0] WIN_END = WIN_W'(ALIGN_WINDOW);
  localparam logic [RUN_W-1:0] RUN_END = RUN_W'(LOCK_COUNT);
  localparam logic [SIZE-1:0]  TOK_0   = SIZE'(10'h354);
  localparam logic [SIZE-1:0]  TOK_1   = SIZE'(10'h0AB);
  localparam logic [SIZE-1:0]  TOK_2   = SIZE'(10'h154);
  localparam logic [SIZE-1:0]  TOK_3   = SIZE'(10'h2AB);

  logic [WIN_W-1:0] win_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic             locked_q;
  logic             align_slip;

  logic             is_token_c;
  logic [WIN_W-1:0] win_inc_c;
  logic [RUN_W-1:0] run_inc_c;

  // Classify the word completing this cycle and precompute counter steps
  always_comb begin
    is_token_c = 1'b0;
    win_inc_c  = win_cnt + WIN_W'(1);
    run_inc_c  = (run_cnt == RUN_END) ? run_cnt : run_cnt + RUN_W'(1);
    if (word_c == TOK_0 || word_c == TOK_1 || word_c == TOK_2 || word_c == TOK_3) begin
      is_token_c = 1'b1;
    end
  end

  // Aligner: count token runs per window, lock on a long run, otherwise
  // slip one bit when the window runs out. External bitslip restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      run_cnt    <= '0;
      locked_q   <= 1'b0;
      align_slip <= 1'b0;
    end else if (bus.bitslip) begin
      win_cnt    <= '0;
      run_cnt    <= '0;
      locked_q   <= 1'b0;
      align_slip <= 1'b0;
    end else begin
      align_slip <= 1'b0;
      if (word_done_c && !locked_q) begin
        if (is_token_c && run_inc_c == RUN_END) begin
          locked_q <= 1'b1;
          run_cnt  <= run_inc_c;
          win_cnt  <= win_inc_c;
        end else if (win_inc_c == WIN_END) begin
          align_slip <= 1'b1;
          win_cnt    <= '0;
          run_cnt    <= '0;
        end else begin
          run_cnt <= is_token_c ? run_inc_c : '0;
          win_cnt <= win_inc_c;
        end
      end
    end
  end

  assign slip_c     = bus.bitslip | align_slip;
  assign bus.locked = locked_q;
`else
  assign slip_c     = bus.bitslip;
  assign bus.locked = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_deserializer.sv
// Self-checking bench for tmds_deserializer. The reference model views the
// input as a bit stream: a word ends on every SIZE-th non-slip bit and equals
// the last SIZE bits received, oldest bit at position 0.
module tb_tmds_deserializer;

  localparam int unsigned SIZE = 10;
`ifdef TMDS_ALIGN_EN
  localparam int unsigned AW = 16;
  localparam int unsigned LC = 8;
`else
  localparam int unsigned AW = 1024;
  localparam int unsigned LC = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tmds_deserializer_if #(.SIZE(SIZE)) bus ();

  tmds_deserializer #(
    .SIZE(SIZE), .ALIGN_WINDOW(AW), .LOCK_COUNT(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         hist[$];
  int         eff;
  logic [9:0] m_word;
  bit         m_valid;
  bit         m_locked;
  int         m_run;
  int         m_win;
  bit         m_pend;

  function automatic logic [9:0] last_word();
    logic [9:0] w;
    for (int j = 0; j < SIZE; j++) w[j] = hist[hist.size() - SIZE + j];
    return w;
  endfunction

  task automatic model_clear();
    hist.delete();
    eff = 0; m_word = '0; m_valid = 0; m_locked = 0;
    m_run = 0; m_win = 0; m_pend = 0;
  endtask

  // Drive one bit for one clock and advance the model; outputs sampled 1 after the edge
  task automatic step(input bit b, input bit sl);
    bit slip;
    bus.s_in = b;
    bus.bitslip = sl;
    @(posedge clk);
    slip = sl | m_pend;
    hist.push_back(b);
    if (hist.size() > SIZE) void'(hist.pop_front());
    m_valid = 0;
    if (!slip) begin
      eff++;
      if (eff % SIZE == 0) begin
        m_valid = 1;
        m_word = last_word();
      end
    end
`ifdef TMDS_ALIGN_EN
    if (sl) begin
      m_run = 0; m_win = 0; m_locked = 0; m_pend = 0;
    end else begin
      m_pend = 0;
      if (m_valid && !m_locked) begin
        bit tok;
        tok = (m_word == 10'h354) || (m_word == 10'h0AB) ||
              (m_word == 10'h154) || (m_word == 10'h2AB);
        if (tok && m_run + 1 >= LC) begin
          m_locked = 1; m_run = LC; m_win++;
        end else if (m_win + 1 == AW) begin
          m_pend = 1; m_win = 0; m_run = 0;
        end else begin
          m_run = tok ? m_run + 1 : 0;
          m_win++;
        end
      end
    end
`endif
    #1;
  endtask

  // One reset cycle with noisy inputs (reset must win over bitslip)
  task automatic do_reset();
    rst_n = 1'b0;
    bus.s_in = 1'b1;
    bus.bitslip = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.bitslip = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 17; i++) step(1'($urandom), 1'b0);
    do_reset();
    checks++;
    if ({bus.p_valid, bus.locked, bus.p_out} !== 12'h000) begin
      errors++;
      $display("FAIL reset: got v=%0b l=%0b w=%h need v=0 l=0 w=000",
               bus.p_valid, bus.locked, bus.p_out);
    end
  endtask

  task automatic test_single();
    logic [9:0] tok = 10'h354;
    do_reset();
    for (int i = 0; i < SIZE; i++) begin
      step(tok[i], 1'b0);
      checks++;
      if (bus.p_valid !== (i == SIZE - 1)) begin
        errors++;
        $display("FAIL single_strobe bit %0d: got v=%0b need v=%0b", i, bus.p_valid, (i == SIZE - 1));
      end
    end
    checks++;
    if (bus.p_out !== 10'h354) begin
      errors++;
      $display("FAIL single_word: got %h need 354", bus.p_out);
    end
    step(1'b0, 1'b0);
    checks++;
    if (bus.p_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drop: got v=%0b need v=0", bus.p_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] w[3];
    int n = 0;
    int t_prev = -1;
    w[0] = 10'h354; w[1] = 10'h0AB; w[2] = 10'h2AB;
    do_reset();
    for (int t = 0; t < 3 * SIZE; t++) begin
      step(w[t / SIZE][t % SIZE], 1'b0);
      if (bus.p_valid === 1'b1) begin
        checks++;
        if (n < 3 && bus.p_out !== w[n]) begin
          errors++;
          $display("FAIL b2b_word %0d: got %h need %h", n, bus.p_out, w[n]);
        end
        if (n > 0) begin
          checks++;
          if (t - t_prev != SIZE) begin
            errors++;
            $display("FAIL b2b_gap %0d: got %0d need %0d", n, t - t_prev, SIZE);
          end
        end
        t_prev = t;
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d need 3", n);
    end
  endtask

  task automatic test_bitslip_single();
    int n = 0;
    int t_prev = -1;
    logic [9:0] exp_w;
    int exp_gap;
    do_reset();
    for (int t = 0; t < 80; t++) begin
      step(t % SIZE == 0, t == 44);
      if (bus.p_valid === 1'b1) begin
        exp_w = (t < 44) ? 10'h001 : 10'h200;
        exp_gap = (t_prev < 44 && t > 44) ? 11 : 10;
        checks++;
        if (bus.p_out !== exp_w) begin
          errors++;
          $display("FAIL slip1_word t=%0d: got %h need %h", t, bus.p_out, exp_w);
        end
        if (t_prev >= 0) begin
          checks++;
          if (t - t_prev != exp_gap) begin
            errors++;
            $display("FAIL slip1_gap t=%0d: got %0d need %0d", t, t - t_prev, exp_gap);
          end
        end
        t_prev = t;
        n++;
      end
    end
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL slip1_count: got %0d need 7", n);
    end
  endtask

  task automatic test_reset_mid();
    bit b;
    do_reset();
    for (int i = 0; i < 2 * SIZE + 5; i++) step(1'($urandom), 1'b0);
    do_reset();
    checks++;
    if ({bus.p_valid, bus.p_out} !== 11'h000) begin
      errors++;
      $display("FAIL rstmid_clear: got v=%0b w=%h need v=0 w=000", bus.p_valid, bus.p_out);
    end
    for (int i = 0; i < SIZE; i++) begin
      b = 1'($urandom);
      step(b, 1'b0);
      checks++;
      if (bus.p_valid !== (i == SIZE - 1) || (i == SIZE - 1 && bus.p_out !== m_word)) begin
        errors++;
        $display("FAIL rstmid_strobe bit %0d: got v=%0b w=%h need v=%0b w=%h",
                 i, bus.p_valid, bus.p_out, (i == SIZE - 1), m_word);
      end
    end
  endtask

  task automatic test_hold();
    bit bits[13];
    logic [9:0] exp_w;
    do_reset();
    for (int i = 0; i < 13; i++) bits[i] = 1'($urandom);
    for (int i = 0; i < 9; i++) step(bits[i], 1'b0);
    for (int i = 9; i < 12; i++) begin
      step(bits[i], 1'b1);
      checks++;
      if (bus.p_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_quiet cyc %0d: got v=%0b need v=0", i, bus.p_valid);
      end
    end
    step(bits[12], 1'b0);
    for (int j = 0; j < SIZE; j++) exp_w[j] = bits[j + 3];
    checks++;
    if (bus.p_valid !== 1'b1 || bus.p_out !== exp_w) begin
      errors++;
      $display("FAIL hold_shift: got v=%0b w=%h need v=1 w=%h", bus.p_valid, bus.p_out, exp_w);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom), 1'b0);
      checks++;
      if ({bus.p_valid, bus.locked, bus.p_out} !== {m_valid, m_locked, m_word}) begin
        errors++;
        $display("FAIL hold_after cyc %0d: got v=%0b l=%0b w=%h need v=%0b l=%0b w=%h",
                 i, bus.p_valid, bus.locked, bus.p_out, m_valid, m_locked, m_word);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    bit sl;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0 && $urandom_range(0, 39) == 0) hold = $urandom_range(1, 4);
      sl = (hold > 0);
      if (hold > 0) hold--;
      step(1'($urandom), sl);
      checks++;
      if ({bus.p_valid, bus.locked, bus.p_out} !== {m_valid, m_locked, m_word}) begin
        errors++;
        $display("FAIL random cyc %0d: got v=%0b l=%0b w=%h need v=%0b l=%0b w=%h",
                 i, bus.p_valid, bus.locked, bus.p_out, m_valid, m_locked, m_word);
      end
    end
  endtask

  task automatic test_align();
    logic [9:0] tok = 10'h354;
    int t = 0;
    int words = 0;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'b0);
    while (t < 2000 && !(bus.locked === 1'b1 && words >= 5)) begin
      step(tok[t % SIZE], 1'b0);
      t++;
      checks++;
      if ({bus.p_valid, bus.locked, bus.p_out} !== {m_valid, m_locked, m_word}) begin
        errors++;
        $display("FAIL align_model cyc %0d: got v=%0b l=%0b w=%h need v=%0b l=%0b w=%h",
                 t, bus.p_valid, bus.locked, bus.p_out, m_valid, m_locked, m_word);
      end
`ifdef TMDS_ALIGN_EN
      if (bus.locked === 1'b1 && bus.p_valid === 1'b1) begin
        words++;
        checks++;
        if (bus.p_out !== 10'h354) begin
          errors++;
          $display("FAIL align_word: got %h need 354", bus.p_out);
        end
      end
`endif
    end
    checks++;
`ifdef TMDS_ALIGN_EN
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL align_lock_timeout: got locked=%0b need 1 within 2000 cycles", bus.locked);
    end
`else
    if (bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL align_disabled: got locked=%0b need 0", bus.locked);
    end
`endif
  endtask

  initial begin
    bus.s_in = 1'b0;
    bus.bitslip = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_bitslip_single();
    test_reset_mid();
    test_hold();
    test_random();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
